// File: rtl/fifo_pkg.sv
// fifo_pkg: shared constants and helpers for the sync_fifo block.
//   FIFO_WIDTH       default data word width
//   FIFO_DEPTH_LOG2  default log2 of the FIFO depth
//   FIFO_COUNT_W     default occupancy-count width (DEPTH_LOG2+1)
//   fifo_depth()     entries for a given DEPTH_LOG2
//   count_width()    occupancy-count width for a given DEPTH_LOG2
package fifo_pkg;

  localparam int FIFO_WIDTH      = 8;
  localparam int FIFO_DEPTH_LOG2 = 2;
  localparam int FIFO_COUNT_W    = FIFO_DEPTH_LOG2 + 1;

  function automatic int fifo_depth(input int depth_log2);
    return 1 << depth_log2;
  endfunction

  // One extra bit so the count can represent DEPTH itself.
  function automatic int count_width(input int depth_log2);
    return depth_log2 + 1;
  endfunction

endpackage

// File: rtl/sync_fifo_if.sv
// sync_fifo_if: producer/consumer bundle of the sync_fifo block.
//   master modport: the user side (drives wr_en/wr_data/rd_en/err_clr)
//   slave modport : the FIFO side (drives rd_data/rd_valid/push/pop/count,
//                   status flags, sticky error flags and pointer debug)
//
// Handshake: wr_en and rd_en are requests that may be held high any time.
// push/pop are the acceptance strobes for the current cycle; a request is
// taken on the rising edge only in a cycle where its strobe is high, and a
// request whose strobe is low is dropped (not queued). rd_valid marks the
// single cycle after an accepted pop in which rd_data carries that word.
interface sync_fifo_if #(
  parameter int WIDTH      = 8,
  parameter int DEPTH_LOG2 = 2
);
  logic                  wr_en;
  logic [WIDTH-1:0]      wr_data;
  logic                  rd_en;
  logic                  err_clr;
  logic [WIDTH-1:0]      rd_data;
  logic                  rd_valid;
  logic                  push;
  logic                  pop;
  logic [DEPTH_LOG2:0]   count;
  logic                  full;
  logic                  empty;
  logic                  almost_full;
  logic                  almost_empty;
  logic                  overflow;
  logic                  underflow;
  logic [DEPTH_LOG2-1:0] dbg_wr_ptr;
  logic [DEPTH_LOG2-1:0] dbg_rd_ptr;

  modport master (
    output wr_en, wr_data, rd_en, err_clr,
    input  rd_data, rd_valid, push, pop, count, full, empty,
           almost_full, almost_empty, overflow, underflow,
           dbg_wr_ptr, dbg_rd_ptr
  );

  modport slave (
    input  wr_en, wr_data, rd_en, err_clr,
    output rd_data, rd_valid, push, pop, count, full, empty,
           almost_full, almost_empty, overflow, underflow,
           dbg_wr_ptr, dbg_rd_ptr
  );
endinterface

// File: rtl/fifo_mem.sv
// fifo_mem: WIDTH x DEPTH register file for sync_fifo.
//   clk/rst        clock, async active-high reset (read register only)
//   we_i/waddr_i/wdata_i  synchronous write port
//   re_i/raddr_i   read enable/address; rdata_o is registered and holds
//                  its value when re_i is low
// The storage array itself is not reset.
module fifo_mem #(
  parameter int WIDTH      = 8,
  parameter int DEPTH_LOG2 = 2
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  we_i,
  input  logic [DEPTH_LOG2-1:0] waddr_i,
  input  logic [WIDTH-1:0]      wdata_i,
  input  logic                  re_i,
  input  logic [DEPTH_LOG2-1:0] raddr_i,
  output logic [WIDTH-1:0]      rdata_o
);
  localparam int DEPTH = 1 << DEPTH_LOG2;

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [WIDTH-1:0] rdata_q;

  always_ff @(posedge clk) begin
    if (we_i) mem_q[waddr_i] <= wdata_i;
  end

  // The FIFO never reads and writes the same entry on one edge, so no
  // write-to-read forwarding is needed.
  always_ff @(posedge clk or posedge rst) begin
    if (rst)       rdata_q <= '0;
    else if (re_i) rdata_q <= mem_q[raddr_i];
  end

  assign rdata_o = rdata_q;
endmodule

// File: rtl/sync_fifo.sv
// sync_fifo: single-clock FIFO with registered (1-cycle) read data.
//   clk  rising-edge clock
//   rst  asynchronous active-high reset; empties the FIFO immediately
//   bus  sync_fifo_if.slave: wr_en/wr_data/rd_en/err_clr in;
//        rd_data/rd_valid, push/pop strobes, count, full/empty,
//        almost_full/almost_empty, overflow/underflow, pointer debug out
// Optional feature macro: FIFO_ERR_FLAGS_EN enables the sticky
// overflow/underflow flags; when undefined they read 0 and err_clr is
// ignored.
module sync_fifo
  import fifo_pkg::*;
#(
  parameter int WIDTH        = FIFO_WIDTH,
  parameter int DEPTH_LOG2   = FIFO_DEPTH_LOG2,
  parameter int ALMOST_FULL  = 3,
  parameter int ALMOST_EMPTY = 1
) (
  input logic        clk,
  input logic        rst,
  sync_fifo_if.slave bus
);
  localparam int DEPTH = fifo_depth(DEPTH_LOG2);
  localparam int CW    = count_width(DEPTH_LOG2);

  logic [DEPTH_LOG2-1:0] wr_ptr_q, wr_ptr_d;
  logic [DEPTH_LOG2-1:0] rd_ptr_q, rd_ptr_d;
  logic [CW-1:0]         count_q, count_d;
  logic                  rd_valid_q, rd_valid_d;
  logic                  full, empty, push, pop;

  // Status is decoded from the registered count only.
  assign full  = (count_q == CW'(DEPTH));
  assign empty = (count_q == '0);

  // Acceptance against the pre-edge count: a full FIFO can still pop
  // (write dropped), an empty one can still push (no bypass to rd_data).
  assign push = bus.wr_en & ~full;
  assign pop  = bus.rd_en & ~empty;

  always_comb begin
    wr_ptr_d   = wr_ptr_q;
    rd_ptr_d   = rd_ptr_q;
    count_d    = count_q;
    rd_valid_d = pop;
    if (push) wr_ptr_d = wr_ptr_q + DEPTH_LOG2'(1);
    if (pop)  rd_ptr_d = rd_ptr_q + DEPTH_LOG2'(1);
    case ({push, pop})
      2'b10:   count_d = count_q + CW'(1);
      2'b01:   count_d = count_q - CW'(1);
      default: count_d = count_q;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr_q   <= '0;
      rd_ptr_q   <= '0;
      count_q    <= '0;
      rd_valid_q <= 1'b0;
    end else begin
      wr_ptr_q   <= wr_ptr_d;
      rd_ptr_q   <= rd_ptr_d;
      count_q    <= count_d;
      rd_valid_q <= rd_valid_d;
    end
  end

  fifo_mem #(
    .WIDTH      (WIDTH),
    .DEPTH_LOG2 (DEPTH_LOG2)
  ) u_mem (
    .clk     (clk),
    .rst     (rst),
    .we_i    (push),
    .waddr_i (wr_ptr_q),
    .wdata_i (bus.wr_data),
    .re_i    (pop),
    .raddr_i (rd_ptr_q),
    .rdata_o (bus.rd_data)
  );

`ifdef FIFO_ERR_FLAGS_EN
  logic ovf_q, ovf_d, unf_q, unf_d;

  // Clear first, then set, so a new error on the clearing edge survives.
  always_comb begin
    ovf_d = ovf_q;
    unf_d = unf_q;
    if (bus.err_clr) begin
      ovf_d = 1'b0;
      unf_d = 1'b0;
    end
    if (bus.wr_en & full & ~bus.rd_en) ovf_d = 1'b1;
    if (bus.rd_en & empty)             unf_d = 1'b1;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      ovf_q <= 1'b0;
      unf_q <= 1'b0;
    end else begin
      ovf_q <= ovf_d;
      unf_q <= unf_d;
    end
  end

  assign bus.overflow  = ovf_q;
  assign bus.underflow = unf_q;
`else
  logic unused_err_clr;
  assign unused_err_clr = bus.err_clr;
  assign bus.overflow   = 1'b0;
  assign bus.underflow  = 1'b0;
`endif

  assign bus.push         = push;
  assign bus.pop          = pop;
  assign bus.count        = count_q;
  assign bus.full         = full;
  assign bus.empty        = empty;
  assign bus.almost_full  = (count_q >= CW'(ALMOST_FULL));
  assign bus.almost_empty = (count_q <= CW'(ALMOST_EMPTY));
  assign bus.rd_valid     = rd_valid_q;
  assign bus.dbg_wr_ptr   = wr_ptr_q;
  assign bus.dbg_rd_ptr   = rd_ptr_q;
endmodule

// File: tb/tb_sync_fifo.sv
// tb_sync_fifo: self-checking bench for sync_fifo (DEPTH=4, WIDTH=8).
// A queue-based model predicts every output; a negedge process compares
// DUT against it each cycle, and directed steps add literal expectations.
module tb_sync_fifo;
  localparam int W   = 8;
  localparam int DL2 = 2;

`ifdef FIFO_ERR_FLAGS_EN
  localparam bit ERR_EN = 1'b1;
`else
  localparam bit ERR_EN = 1'b0;
`endif

  logic clk;
  logic rst;
  int   checks   = 0;
  int   failures = 0;
  bit   chk_on   = 1'b0;
  logic last_push;
  logic last_pop;

  sync_fifo_if #(.WIDTH(W), .DEPTH_LOG2(DL2)) bus ();

  sync_fifo #(
    .WIDTH(W), .DEPTH_LOG2(DL2), .ALMOST_FULL(3), .ALMOST_EMPTY(1)
  ) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  // ---------------- clock / reset ----------------
  initial clk = 1'b0;
  always #5 clk = ~clk;

  // ---------------- model ----------------
  logic [W-1:0] exp_q[$];
  logic [W-1:0] m_rd_data  = '0;
  logic         m_rd_valid = 1'b0;
  logic         m_ovf      = 1'b0;
  logic         m_unf      = 1'b0;
  int           m_pushes   = 0;
  int           m_pops     = 0;

  always @(posedge clk or posedge rst) begin
    int  n;
    bit  do_push, do_pop;
    if (rst) begin
      exp_q.delete();
      m_rd_data  = '0;
      m_rd_valid = 1'b0;
      m_ovf      = 1'b0;
      m_unf      = 1'b0;
      m_pushes   = 0;
      m_pops     = 0;
    end else begin
      n       = exp_q.size();
      do_push = bus.wr_en && (n < 4);
      do_pop  = bus.rd_en && (n > 0);
      m_rd_valid = do_pop;
      if (do_pop) begin
        m_rd_data = exp_q.pop_front();
        m_pops++;
      end
      if (do_push) begin
        exp_q.push_back(bus.wr_data);
        m_pushes++;
      end
      if (ERR_EN) begin
        if (bus.err_clr) begin
          m_ovf = 1'b0;
          m_unf = 1'b0;
        end
        if (bus.wr_en && n == 4 && !bus.rd_en) m_ovf = 1'b1;
        if (bus.rd_en && n == 0)               m_unf = 1'b1;
      end
    end
  end

  // ---------------- scoreboard ----------------
  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%0h expected=%0h t=%0t", name, act, exp, $time);
    end
  endtask

  always @(negedge clk) begin
    int n;
    if (chk_on) begin
      n = exp_q.size();
      chk("count",        32'(bus.count),        32'(n));
      chk("full",         32'(bus.full),         32'(n == 4));
      chk("empty",        32'(bus.empty),        32'(n == 0));
      chk("almost_full",  32'(bus.almost_full),  32'(n >= 3));
      chk("almost_empty", 32'(bus.almost_empty), 32'(n <= 1));
      chk("push",         32'(bus.push),         32'(bus.wr_en && n < 4));
      chk("pop",          32'(bus.pop),          32'(bus.rd_en && n > 0));
      chk("rd_valid",     32'(bus.rd_valid),     32'(m_rd_valid));
      chk("rd_data",      32'(bus.rd_data),      32'(m_rd_data));
      chk("overflow",     32'(bus.overflow),     32'(m_ovf));
      chk("underflow",    32'(bus.underflow),    32'(m_unf));
      chk("wr_ptr",       32'(bus.dbg_wr_ptr),   32'(m_pushes % 4));
      chk("rd_ptr",       32'(bus.dbg_rd_ptr),   32'(m_pops % 4));
    end
  end

  // ---------------- driver ----------------
  // Called just after a rising edge; applies inputs, captures the
  // combinational strobes, then advances one edge.
  task automatic step(input logic w, input logic [W-1:0] d, input logic r, input logic c);
    bus.wr_en   = w;
    bus.wr_data = d;
    bus.rd_en   = r;
    bus.err_clr = c;
    #1;
    last_push = bus.push;
    last_pop  = bus.pop;
    @(posedge clk);
    #1;
  endtask

  task automatic idle();
    step(1'b0, 8'h00, 1'b0, 1'b0);
  endtask

  // ---------------- directed stimulus ----------------
  initial begin
    logic [W-1:0] seq1 [3];
    seq1[0] = 8'hA1; seq1[1] = 8'hB2; seq1[2] = 8'hC3;
    rst = 1'b1;
    bus.wr_en = 1'b0; bus.wr_data = '0; bus.rd_en = 1'b0; bus.err_clr = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    chk("rst_count",    32'(bus.count),        32'd0);
    chk("rst_empty",    32'(bus.empty),        32'd1);
    chk("rst_aempty",   32'(bus.almost_empty), 32'd1);
    chk("rst_full",     32'(bus.full),         32'd0);
    chk("rst_afull",    32'(bus.almost_full),  32'd0);
    chk("rst_rd_valid", 32'(bus.rd_valid),     32'd0);
    chk("rst_rd_data",  32'(bus.rd_data),      32'd0);
    chk("rst_ovf",      32'(bus.overflow),     32'd0);
    chk("rst_unf",      32'(bus.underflow),    32'd0);
    rst = 1'b0;
    chk_on = 1'b1;

    // Push A1,B2,C3 then pop three.
    for (int i = 0; i < 3; i++) begin
      step(1'b1, seq1[i], 1'b0, 1'b0);
      chk("t1_push_count", 32'(bus.count), 32'(i + 1));
    end
    for (int i = 0; i < 3; i++) begin
      step(1'b0, 8'h00, 1'b1, 1'b0);
      chk("t1_rd_data",   32'(bus.rd_data),  32'(seq1[i]));
      chk("t1_rd_valid",  32'(bus.rd_valid), 32'd1);
      chk("t1_pop_count", 32'(bus.count),    32'(2 - i));
    end
    chk("t1_empty", 32'(bus.empty), 32'd1);
    idle();
    chk("t1_rd_valid_one_cycle", 32'(bus.rd_valid), 32'd0);

    // Overfill with 0x10..0x14.
    for (int i = 0; i < 5; i++) step(1'b1, 8'h10 + 8'(i), 1'b0, 1'b0);
    chk("t2_fifth_push", 32'(last_push),    32'd0);
    chk("t2_count",      32'(bus.count),    32'd4);
    chk("t2_full",       32'(bus.full),     32'd1);
    chk("t2_overflow",   32'(bus.overflow), 32'(ERR_EN));
    idle();
    chk("t2_ovf_sticky", 32'(bus.overflow), 32'(ERR_EN));
    step(1'b0, 8'h00, 1'b0, 1'b1);
    chk("t2_ovf_clr",    32'(bus.overflow), 32'd0);

    // Full with simultaneous request: pop only.
    step(1'b1, 8'h99, 1'b1, 1'b0);
    chk("t3_push",     32'(last_push),    32'd0);
    chk("t3_pop",      32'(last_pop),     32'd1);
    chk("t3_count",    32'(bus.count),    32'd3);
    chk("t3_rd_data",  32'(bus.rd_data),  32'h10);
    chk("t3_overflow", 32'(bus.overflow), 32'd0);
    for (int i = 0; i < 3; i++) begin
      step(1'b0, 8'h00, 1'b1, 1'b0);
      chk("t3_drain", 32'(bus.rd_data), 32'h11 + 32'(i));
    end

    // Steady state at count=2 with pointer wrap.
    step(1'b1, 8'h20, 1'b0, 1'b0);
    step(1'b1, 8'h21, 1'b0, 1'b0);
    for (int i = 0; i < 10; i++) begin
      step(1'b1, 8'h22 + 8'(i), 1'b1, 1'b0);
      chk("t4_count",   32'(bus.count),   32'd2);
      chk("t4_rd_data", 32'(bus.rd_data), 32'h20 + 32'(i));
    end
    chk("t4_wr_ptr", 32'(bus.dbg_wr_ptr), 32'd3);
    chk("t4_rd_ptr", 32'(bus.dbg_rd_ptr), 32'd1);
    step(1'b0, 8'h00, 1'b1, 1'b0);
    chk("t4_tail0", 32'(bus.rd_data), 32'h2A);
    step(1'b0, 8'h00, 1'b1, 1'b0);
    chk("t4_tail1", 32'(bus.rd_data), 32'h2B);

    // Empty read, empty read+write, error clear behaviour.
    step(1'b0, 8'h00, 1'b1, 1'b0);
    chk("t5_rd_valid",  32'(bus.rd_valid),  32'd0);
    chk("t5_count",     32'(bus.count),     32'd0);
    chk("t5_underflow", 32'(bus.underflow), 32'(ERR_EN));
    step(1'b1, 8'h77, 1'b1, 1'b0);
    chk("t5_both_push",  32'(last_push),    32'd1);
    chk("t5_both_pop",   32'(last_pop),     32'd0);
    chk("t5_both_count", 32'(bus.count),    32'd1);
    chk("t5_no_bypass",  32'(bus.rd_valid), 32'd0);
    step(1'b0, 8'h00, 1'b1, 1'b1);
    chk("t5_unf_clr",  32'(bus.underflow), 32'd0);
    chk("t5_rd_data",  32'(bus.rd_data),   32'h77);
    step(1'b0, 8'h00, 1'b1, 1'b1);
    chk("t5_set_wins", 32'(bus.underflow), 32'(ERR_EN));
    step(1'b0, 8'h00, 1'b0, 1'b1);
    chk("t5_clr_only", 32'(bus.underflow), 32'd0);

    // Asynchronous reset with count=3 and a word in flight.
    step(1'b1, 8'h30, 1'b0, 1'b0);
    step(1'b1, 8'h31, 1'b0, 1'b0);
    step(1'b1, 8'h32, 1'b0, 1'b0);
    step(1'b1, 8'h33, 1'b1, 1'b0);
    chk("t6_pre_count", 32'(bus.count),    32'd3);
    chk("t6_pre_valid", 32'(bus.rd_valid), 32'd1);
    bus.wr_en = 1'b0; bus.rd_en = 1'b0;
    #1 rst = 1'b1;
    #1;
    chk("t6_rst_count", 32'(bus.count),    32'd0);
    chk("t6_rst_empty", 32'(bus.empty),    32'd1);
    chk("t6_rst_valid", 32'(bus.rd_valid), 32'd0);
    rst = 1'b0;
    @(posedge clk);
    #1;
    step(1'b1, 8'h5A, 1'b0, 1'b0);
    step(1'b0, 8'h00, 1'b1, 1'b0);
    chk("t6_after_data",  32'(bus.rd_data),  32'h5A);
    chk("t6_after_valid", 32'(bus.rd_valid), 32'd1);
    idle();
    idle();

    chk_on = 1'b0;
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule

// File: doc/sync_fifo.md
# sync_fifo

Synchronous single-clock FIFO for the datapath front end that buffers words between a producer and a consumer. It generates the qualified push/pop strobes and the occupancy count that a downstream occupancy counter or threshold monitor consumes. Storage is a small register file. Reads have one cycle of latency.

## Interface
- WIDTH, 8, data word width in bits
- DEPTH_LOG2, 2, log2 of depth; DEPTH = 2**DEPTH_LOG2 entries
- ALMOST_FULL, 3, almost_full asserts when count >= this value
- ALMOST_EMPTY, 1, almost_empty asserts when count <= this value

Ports (reset rst, asynchronous, active-high; clock clk):
- clk  in  1  clock, rising edge
- rst  in  1  asynchronous active-high reset
- wr_en  in  1  push request
- wr_data  in  WIDTH  push data
- rd_en  in  1  pop request
- rd_data  out  WIDTH  popped word, registered
- rd_valid  out  1  rd_data holds a word popped on the previous edge
- push  out  1  push accepted this cycle (combinational)
- pop  out  1  pop accepted this cycle (combinational)
- count  out  DEPTH_LOG2+1  occupancy, 0..DEPTH
- full / empty  out  1 each  count==DEPTH / count==0
- almost_full / almost_empty  out  1 each  threshold flags
- err_clr  in  1  clears sticky error flags
- overflow / underflow  out  1 each  sticky error flags (see Configuration)

## Operation
- push = wr_en & ~full; pop = rd_en & ~empty. Evaluate both against the pre-edge count.
- When full and wr_en & rd_en are both high: only the pop is accepted. The write is dropped.
- When empty and wr_en & rd_en are both high: only the push is accepted. There is no bypass, and rd_valid stays 0.
- On an accepted push: mem[wr_ptr] <= wr_data and wr_ptr increments. On an accepted pop: rd_data <= mem[rd_ptr] and rd_ptr increments.
- Pointers are DEPTH_LOG2 bits wide and wrap modulo DEPTH from DEPTH-1 to 0.
- count update per edge:
  - +1 on push only
  - -1 on pop only
  - unchanged when both are accepted or neither is
  - count never exceeds DEPTH and never underflows.
- rd_data holds its last value when there is no pop.
- Flags are combinational from the registered count, so they reflect the new count immediately after the edge.
- Reset values:
  - wr_ptr = 0, rd_ptr = 0, count = 0
  - rd_data = 0, rd_valid = 0
  - empty = 1, almost_empty = 1, full = 0, almost_full = 0
  - overflow = 0, underflow = 0
- Memory contents are not reset.
- rst asserted mid-operation discards all contents immediately, without waiting for an edge.

## Timing
- Write-to-read latency: a word pushed at edge N can be popped at edge N+1 and appears on rd_data after edge N+1 with rd_valid=1.
- rd_valid = 1 for exactly one cycle per accepted pop.
- push and pop are valid in the same cycle as wr_en and rd_en.
- Sustained throughput is one push and one pop per cycle when 0 < count < DEPTH.

## Configuration
- FIFO_ERR_FLAGS_EN defined:
  - overflow sets on any edge where wr_en & full & ~rd_en.
  - underflow sets on any edge where rd_en & empty.
  - Both flags are sticky until err_clr (synchronous) or rst. If err_clr and a new error occur on the same edge, the set wins.
- FIFO_ERR_FLAGS_EN undefined: overflow and underflow are tied to 0 and err_clr is ignored. The ports remain present in both builds.

## Structure
- fifo_pkg holds:
  - the default WIDTH and DEPTH_LOG2 constants
  - a depth function returning 2**DEPTH_LOG2
  - a count-width constant DEPTH_LOG2+1.
- Sub-module fifo_mem: a register-file array, WIDTH x DEPTH, with one synchronous write port and one registered read port. No reset on the array.
- Pointer, count and flag logic live in sync_fifo.

## Test plan
- Reset, then push 0xA1, 0xB2, 0xC3, then pop 3 times:
  - rd_data sequence is A1, B2, C3, each with rd_valid
  - count steps 1,2,3,2,1,0
  - empty returns to 1.
- Push 5 words 0x10..0x14 into the DEPTH=4 FIFO:
  - full=1 after the 4th push, and the 5th push=0
  - count stays at 4
  - with FIFO_ERR_FLAGS_EN, overflow=1 and stays 1 until err_clr.
- Fill to 4, then hold wr_en=rd_en=1 for one cycle: pop only, count becomes 3, the oldest word is output, and the write is dropped.
- Hold count=2 with wr_en=rd_en=1 for 10 cycles:
  - count stays 2
  - pointers wrap past 3 to 0
  - output order matches input order.
- When empty, assert rd_en: rd_valid=0, count=0, and underflow=1 (with the macro) or 0 (without it).
- With count=3, assert rst asynchronously between edges:
  - count=0, empty=1 and rd_valid=0 immediately
  - a subsequent push/pop of 0x5A returns 0x5A.
